// File: rtl/dance_judge_pkg.sv
// Shared definitions for the dance judge: arrow codes, FSM encoding and helpers.
// Also intended for reuse by the arrow generator and display logic.
package dance_judge_pkg;

  typedef enum logic [2:0] {
    UP    = 3'd0,
    DOWN  = 3'd1,
    LEFT  = 3'd2,
    RIGHT = 3'd3,
    NONE  = 3'd4
  } arrow_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_JUDGE = 2'd2
  } state_e;

  localparam int unsigned CNT_W     = 24;
  localparam logic [7:0]  COMBO_MAX = 8'hFF;

  // Codes 5-7 behave exactly like NONE.
  function automatic logic is_target(input logic [2:0] code);
    return code < 3'(NONE);
  endfunction

  function automatic logic [3:0] arrow_mask(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/dance_judge_if.sv
// Player/game-side signal bundle of the dance judge.
interface dance_judge_if;
  logic        step;
  logic [2:0]  arrow;
  logic [3:0]  btn;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic        hit_pulse;
  logic        miss_pulse;
  logic        armed;

  modport master (
    output step, arrow, btn,
    input  score, combo, max_combo, hit_pulse, miss_pulse, armed
  );

  modport slave (
    input  step, arrow, btn,
    output score, combo, max_combo, hit_pulse, miss_pulse, armed
  );
endinterface

// File: rtl/dance_judge_btn_edge.sv
// 4-bit rising-edge detector; history is preloaded with btn during reset so
// buttons held across reset release never count as presses.
module btn_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [3:0] press
);
  logic [3:0] prev_q, prev_d;

  always_comb begin
    prev_d = btn;
    press  = rst ? '0 : (btn & ~prev_q);
  end

  always_ff @(posedge clk) begin
    prev_q <= prev_d;
  end
endmodule

// File: rtl/dance_judge.sv
// Rhythm-game judge: latches a target arrow, waits a timed window for the
// matching button press and keeps score, combo and best combo.
module dance_judge
  import dance_judge_pkg::*;
#(
  parameter int unsigned WINDOW      = 12_500_000,
  parameter int unsigned POINTS      = 10,
  parameter int unsigned COMBO_BONUS = 10
) (
  input  logic          clk,
  input  logic          rst,
  dance_judge_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
  localparam logic [16:0]      ADD_1    = 17'(POINTS);
  localparam logic [16:0]      ADD_2    = 17'(2 * POINTS);

  state_e           state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      score_q, score_d;
  logic [7:0]       combo_q, combo_d;
  logic [7:0]       max_q, max_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;
  logic             armed_q, armed_d;

  logic [3:0]  press;
  logic [3:0]  want;
  logic        live;
  logic        hit;
  logic        miss;
  logic        new_tgt;
  logic [16:0] add;
  logic [16:0] sum;

  btn_edge u_edge (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn),
    .press (press)
  );

  always_comb begin
    // A target latched alongside a judgment is already live during the JUDGE cycle.
    live    = (state_q == ST_ARMED) || ((state_q == ST_JUDGE) && armed_q);
    want    = arrow_mask(code_q);
    hit     = live && (press == want) && (bus.btn == want);
    miss    = live && !hit && ((|press) || bus.step || (cnt_q == CNT_LAST));
    new_tgt = bus.step && is_target(bus.arrow);
    add     = (32'(combo_q) >= COMBO_BONUS) ? ADD_2 : ADD_1;
    sum     = {1'b0, score_q} + add;

    code_d  = code_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    combo_d = combo_q;
    max_d   = max_q;
    hit_d   = hit;
    miss_d  = miss;
    armed_d = armed_q;

    if (hit) begin
      score_d = sum[16] ? '1 : sum[15:0];
      combo_d = (combo_q == COMBO_MAX) ? combo_q : combo_q + 8'd1;
      if (combo_d > max_q) max_d = combo_d;
    end else if (miss) begin
      combo_d = '0;
    end

    // A step always closes any live target (via hit or miss above) before latching.
    if (bus.step) begin
      armed_d = new_tgt;
      if (new_tgt) begin
        code_d = bus.arrow[1:0];
        cnt_d  = '0;
      end
    end else if (hit || miss) begin
      armed_d = 1'b0;
    end else if (live) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (hit || miss)  state_d = ST_JUDGE;
    else if (armed_d) state_d = ST_ARMED;
    else              state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      score_q <= '0;
      combo_q <= '0;
      max_q   <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      combo_q <= combo_d;
      max_q   <= max_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      armed_q <= armed_d;
    end
  end

  assign bus.score      = score_q;
  assign bus.combo      = combo_q;
  assign bus.max_combo  = max_q;
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.armed      = armed_q;
endmodule

// File: tb/tb_dance_judge.sv
// Self-checking bench for dance_judge: fixed vector table, directed corner
// sequences and random traffic against a behavioural scoring model.
module tb_dance_judge;
  localparam int unsigned W  = 8;
  localparam int unsigned P  = 10;
  localparam int unsigned CB = 2;

  logic clk = 1'b0;
  logic rst;

  dance_judge_if bus ();

  dance_judge #(.WINDOW(W), .POINTS(P), .COMBO_BONUS(CB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: a pending target with an age, plus the scoreboard.
  bit         m_armed, m_hit, m_miss;
  int         m_code, m_age, m_score, m_combo, m_max;
  logic [3:0] m_prev;

  typedef struct {
    bit         r;
    bit         s;
    int         a;
    logic [3:0] b;
    bit         hit;
    bit         miss;
    bit         armed;
    int         score;
    int         combo;
    int         maxc;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  function void model_cycle(input bit r, input bit s, input int a, input logic [3:0] b);
    logic [3:0] edges;
    m_hit  = 0;
    m_miss = 0;
    if (r) begin
      m_armed = 0; m_code = 0; m_age = 0;
      m_score = 0; m_combo = 0; m_max = 0;
      m_prev  = b;
      return;
    end
    edges  = b & ~m_prev;
    m_prev = b;
    if (m_armed) begin
      if (edges != 4'b0000) begin
        m_hit  = ($countones(edges) == 1) && ($countones(b) == 1) && edges[m_code];
        m_miss = !m_hit;
      end else if (m_age == int'(W) - 1 || s) begin
        m_miss = 1;
      end else begin
        m_age++;
      end
    end
    if (m_hit) begin
      m_score = imin(m_score + ((m_combo >= int'(CB)) ? 2 * int'(P) : int'(P)), 65535);
      m_combo = imin(m_combo + 1, 255);
      if (m_combo > m_max) m_max = m_combo;
    end else if (m_miss) begin
      m_combo = 0;
    end
    if (s) begin
      if (a < 4) begin
        m_armed = 1; m_code = a; m_age = 0;
      end else begin
        m_armed = 0;
      end
    end else if (m_hit || m_miss) begin
      m_armed = 0;
    end
  endfunction

  task automatic check_model();
    chk("model_hit",   int'(bus.hit_pulse),  int'(m_hit));
    chk("model_miss",  int'(bus.miss_pulse), int'(m_miss));
    chk("model_armed", int'(bus.armed),      int'(m_armed));
    chk("model_score", int'(bus.score),      m_score);
    chk("model_combo", int'(bus.combo),      m_combo);
    chk("model_max",   int'(bus.max_combo),  m_max);
  endtask

  task automatic tick(input bit r, input bit s, input int a, input logic [3:0] b);
    rst      = r;
    bus.step = s;
    bus.arrow = 3'(a);
    bus.btn  = b;
    @(posedge clk);
    model_cycle(r, s, a, b);
    #1;
    check_model();
  endtask

  initial begin
    int got;
    logic [3:0] rb;

    //          r  s  a  btn      hit miss armed score combo max
    vt[0]  = '{0, 1, 2, 4'b0000, 0, 0, 1,  0, 0, 0};
    vt[1]  = '{0, 0, 0, 4'b0000, 0, 0, 1,  0, 0, 0};
    vt[2]  = '{0, 0, 0, 4'b0000, 0, 0, 1,  0, 0, 0};
    vt[3]  = '{0, 0, 0, 4'b0100, 1, 0, 0, 10, 1, 1};
    vt[4]  = '{0, 0, 0, 4'b0100, 0, 0, 0, 10, 1, 1};
    vt[5]  = '{0, 0, 0, 4'b0000, 0, 0, 0, 10, 1, 1};
    vt[6]  = '{0, 1, 2, 4'b0000, 0, 0, 1, 10, 1, 1};
    vt[7]  = '{0, 0, 0, 4'b0100, 1, 0, 0, 20, 2, 2};
    vt[8]  = '{0, 1, 2, 4'b0000, 0, 0, 1, 20, 2, 2};
    vt[9]  = '{0, 0, 0, 4'b0100, 1, 0, 0, 40, 3, 3};
    vt[10] = '{0, 1, 3, 4'b0000, 0, 0, 1, 40, 3, 3};
    vt[11] = '{0, 0, 0, 4'b0001, 0, 1, 0, 40, 0, 3};
    vt[12] = '{0, 1, 4, 4'b0000, 0, 0, 0, 40, 0, 3};
    vt[13] = '{0, 0, 0, 4'b0001, 0, 0, 0, 40, 0, 3};
    vt[14] = '{0, 0, 0, 4'b0000, 0, 0, 0, 40, 0, 3};
    vt[15] = '{0, 1, 0, 4'b0000, 0, 0, 1, 40, 0, 3};
    vt[16] = '{0, 0, 0, 4'b0011, 0, 1, 0, 40, 0, 3};
    vt[17] = '{0, 0, 0, 4'b0000, 0, 0, 0, 40, 0, 3};

    rst = 1'b1; bus.step = 1'b0; bus.arrow = '0; bus.btn = '0;
    m_prev = '0;

    tick(1, 0, 0, 4'b0000);
    tick(1, 0, 0, 4'b0000);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_combo", int'(bus.combo), 0);
    chk("rst_max",   int'(bus.max_combo), 0);
    chk("rst_armed", int'(bus.armed), 0);
    chk("rst_pulse", int'(bus.hit_pulse) + int'(bus.miss_pulse), 0);

    foreach (vt[i]) begin
      tick(vt[i].r, vt[i].s, vt[i].a, vt[i].b);
      chk($sformatf("vec%0d_hit", i),   int'(bus.hit_pulse),  int'(vt[i].hit));
      chk($sformatf("vec%0d_miss", i),  int'(bus.miss_pulse), int'(vt[i].miss));
      chk($sformatf("vec%0d_armed", i), int'(bus.armed),      int'(vt[i].armed));
      chk($sformatf("vec%0d_score", i), int'(bus.score),      vt[i].score);
      chk($sformatf("vec%0d_combo", i), int'(bus.combo),      vt[i].combo);
      chk($sformatf("vec%0d_max", i),   int'(bus.max_combo),  vt[i].maxc);
    end

    // Timeout: miss arrives WINDOW cycles after armed rises.
    tick(0, 1, 1, 4'b0000);
    tick(0, 0, 0, 4'b0010);
    tick(0, 0, 0, 4'b0000);
    chk("pre_timeout_combo", int'(bus.combo), 1);
    tick(0, 1, 1, 4'b0000);
    chk("timeout_armed_rise", int'(bus.armed), 1);
    got = 0;
    for (int j = 1; j <= 20; j++) begin
      tick(0, 0, 0, 4'b0000);
      if (bus.miss_pulse === 1'b1) begin
        got = j;
        break;
      end
    end
    chk("timeout_latency", got, int'(W));
    chk("timeout_combo", int'(bus.combo), 0);
    chk("timeout_armed", int'(bus.armed), 0);

    // Step and correct press in the same cycle.
    tick(0, 1, 0, 4'b0000);
    tick(0, 1, 3, 4'b0001);
    chk("samecyc_hit",   int'(bus.hit_pulse), 1);
    chk("samecyc_armed", int'(bus.armed), 1);
    chk("samecyc_score", int'(bus.score), 60);
    tick(0, 0, 0, 4'b1000);
    chk("newtgt_hit",   int'(bus.hit_pulse), 1);
    chk("newtgt_score", int'(bus.score), 70);
    chk("newtgt_combo", int'(bus.combo), 2);
    tick(0, 0, 0, 4'b0000);

    // Reset mid-window, step during reset, button held through release.
    tick(0, 1, 2, 4'b0000);
    tick(0, 0, 0, 4'b0000);
    tick(1, 0, 0, 4'b0000);
    chk("midrst_pulse", int'(bus.hit_pulse) + int'(bus.miss_pulse), 0);
    chk("midrst_armed", int'(bus.armed), 0);
    chk("midrst_score", int'(bus.score), 0);
    chk("midrst_max",   int'(bus.max_combo), 0);
    tick(1, 1, 0, 4'b0100);
    chk("step_in_rst_armed", int'(bus.armed), 0);
    tick(0, 1, 2, 4'b0100);
    chk("held_armed", int'(bus.armed), 1);
    tick(0, 0, 0, 4'b0100);
    chk("held_no_hit",  int'(bus.hit_pulse), 0);
    chk("held_no_miss", int'(bus.miss_pulse), 0);
    tick(0, 0, 0, 4'b0000);
    tick(0, 0, 0, 4'b0100);
    chk("repress_hit",   int'(bus.hit_pulse), 1);
    chk("repress_score", int'(bus.score), 10);

    // Random traffic against the model.
    rb = 4'b0000;
    for (int n = 0; n < 4000; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel >= 5 && sel <= 7) rb = 4'b0001 << $urandom_range(0, 3);
      else if (sel == 8)        rb = 4'b0000;
      else if (sel == 9)        rb = 4'($urandom);
      tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 7)), rb);
    end

    // Saturation of score and combo.
    tick(1, 0, 0, 4'b0000);
    for (int k = 0; k < 3400; k++) begin
      tick(0, 1, 0, 4'b0000);
      tick(0, 0, 0, 4'b0001);
    end
    tick(0, 0, 0, 4'b0000);
    chk("sat_score", int'(bus.score), 65535);
    chk("sat_combo", int'(bus.combo), 255);
    chk("sat_max",   int'(bus.max_combo), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
